// File: rtl/our_decoder_pkg.sv
// Shared defaults, storage-state encoding and decode helper for the 4-to-16 one-hot decoder.
// Optional build macro used across this slice: OURDECODER_RANGE_ERR_EN (adds out_err).
package our_decoder_pkg;

    localparam int IDX_W_DEF    = 4;
    localparam int OUT_N_DEF    = 16;
    // Widest one-hot word the helper can build; OUT_N must not exceed this.
    localparam int ONEHOT_MAX_W = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } store_state_e;

    // Returns 1 << idx, or all zeros when idx falls outside the n-bit word.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot_of(input int unsigned idx,
                                                          input int unsigned n);
        logic [ONEHOT_MAX_W-1:0] word;
        word = '0;
        if (idx < n && idx < ONEHOT_MAX_W)
            word = ONEHOT_MAX_W'(1) << idx;
        return word;
    endfunction

endpackage

// File: rtl/our_decoder_if.sv
// Valid/ready bus between an index producer and the one-hot decoder.
// out_err exists only when OURDECODER_RANGE_ERR_EN is defined.
interface our_decoder_if
    import our_decoder_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int OUT_N = OUT_N_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_index;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_N-1:0] out_onehot;
`ifdef OURDECODER_RANGE_ERR_EN
    logic             out_err;
`endif

    modport master (
        output in_valid, in_index, out_ready,
`ifdef OURDECODER_RANGE_ERR_EN
        input  out_err,
`endif
        input  in_ready, out_valid, out_onehot
    );

    modport slave (
        input  in_valid, in_index, out_ready,
`ifdef OURDECODER_RANGE_ERR_EN
        output out_err,
`endif
        output in_ready, out_valid, out_onehot
    );

endinterface

// File: rtl/our_decoder_skid.sv
// Generic 2-entry valid/ready skid buffer: full throughput, registered in_ready and outputs.
// out_data is forced to zero whenever out_valid is low.
module our_decoder_skid
    import our_decoder_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    store_state_e state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         in_fire, out_fire;

    always_comb begin
        in_fire  = in_valid & in_ready_q;
        out_fire = out_valid_q & out_ready;
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (out_fire) begin
                    main_d  = '0;
                    state_d = EMPTY;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = ONE;
                end
            end
            default: begin
                main_d  = '0;
                skid_d  = '0;
                state_d = EMPTY;
            end
        endcase
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/our_decoder.sv
// Registered binary-index to one-hot decoder behind a 2-entry skid buffer.
// Define OURDECODER_RANGE_ERR_EN to carry an out-of-range flag (out_err) with each word.
module our_decoder
    import our_decoder_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int OUT_N = OUT_N_DEF   // 2 <= OUT_N <= 2**IDX_W, and OUT_N <= ONEHOT_MAX_W
) (
    input  logic        clk,
    input  logic        rst,
    our_decoder_if.slave bus
);

`ifdef OURDECODER_RANGE_ERR_EN
    localparam int DATA_W = OUT_N + 1;
`else
    localparam int DATA_W = OUT_N;
`endif

    logic [OUT_N-1:0]  dec;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out_data;

    // Out-of-range indices decode to all zeros; the entry still takes a slot.
    always_comb begin
        dec = OUT_N'(onehot_of(32'(bus.in_index), OUT_N));
`ifdef OURDECODER_RANGE_ERR_EN
        in_data = {(32'(bus.in_index) >= 32'(OUT_N)), dec};
`else
        in_data = dec;
`endif
    end

    our_decoder_skid #(
        .W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    assign bus.out_onehot = out_data[OUT_N-1:0];
`ifdef OURDECODER_RANGE_ERR_EN
    assign bus.out_err    = out_data[OUT_N];
`endif

endmodule

// File: tb/tb_our_decoder.sv
// Scoreboard bench for our_decoder (16-wide) plus a 12-wide instance for out-of-range handling.
// out_err checks are compiled in when OURDECODER_RANGE_ERR_EN is defined.
module tb_our_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    our_decoder_if #(.IDX_W(4), .OUT_N(16)) bus ();
    our_decoder_if #(.IDX_W(4), .OUT_N(12)) bus12 ();

    our_decoder #(.IDX_W(4), .OUT_N(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    our_decoder #(.IDX_W(4), .OUT_N(12)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          pushed = 0;
    int          popped = 0;
    logic [15:0] sb[$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_word  = '0;

    function automatic int enc16(input logic [15:0] w);
        for (int i = 0; i < 16; i++)
            if (w[i]) return i;
        return -1;
    endfunction

    // Called at a falling edge: samples just before the next rising edge, runs the
    // scoreboard on the transfers that edge will perform, then returns at the next falling edge.
    task automatic tick();
        logic [15:0] exp_w;
        #4;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_onehot !== prev_word) begin
                    errors++;
                    $display("FAIL hold: valid=%b word=%h, required valid=1 word=%h",
                             bus.out_valid, bus.out_onehot, prev_word);
                end
            end
            if (bus.out_valid !== 1'b1) begin
                checks++;
                if (bus.out_onehot !== 16'h0000) begin
                    errors++;
                    $display("FAIL idle_zero: word=%h, required 0000", bus.out_onehot);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                popped++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got word=%h, required no output", bus.out_onehot);
                end else begin
                    exp_w = sb.pop_front();
                    if (bus.out_onehot !== exp_w) begin
                        errors++;
                        $display("FAIL sb_data: got %h, required %h", bus.out_onehot, exp_w);
                    end
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                sb.push_back(16'h0001 << bus.in_index);
                pushed++;
            end
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_word  = bus.out_onehot;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_onehot !== 16'h0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b word=%h ready=%b, required 0/0000/1",
                     bus.out_valid, bus.out_onehot, bus.in_ready);
        end
        checks++;
        if (bus12.out_valid !== 1'b0 || bus12.out_onehot !== 12'h0 || bus12.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state12: valid=%b word=%h ready=%b, required 0/000/1",
                     bus12.out_valid, bus12.out_onehot, bus12.in_ready);
        end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_index  = 4'd5;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_onehot !== 16'h0020) begin
            errors++;
            $display("FAIL single: valid=%b word=%h, required 1/0020", bus.out_valid, bus.out_onehot);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_sweep();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_index = 4'(i);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || enc16(bus.out_onehot) != i ||
                bus.out_onehot !== (16'h0001 << i)) begin
                errors++;
                $display("FAIL sweep[%0d]: valid=%b word=%h, required 1/%h",
                         i, bus.out_valid, bus.out_onehot, 16'h0001 << i);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end: valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_index  = 4'd3;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_onehot !== 16'h0008) begin
            errors++;
            $display("FAIL bp_first: ready=%b word=%h, required 1/0008", bus.in_ready, bus.out_onehot);
        end
        bus.in_index = 4'd9;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_onehot !== 16'h0008) begin
            errors++;
            $display("FAIL bp_full: ready=%b valid=%b word=%h, required 0/1/0008",
                     bus.in_ready, bus.out_valid, bus.out_onehot);
        end
        bus.in_index = 4'd7;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_onehot !== 16'h0008) begin
            errors++;
            $display("FAIL bp_ignore: ready=%b word=%h, required 0/0008", bus.in_ready, bus.out_onehot);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_onehot !== 16'h0200 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: word=%h ready=%b, required 0200/1", bus.out_onehot, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        int p0 = pushed;
        int q0 = popped;
        for (int n = 0; n < 1000; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_index  = 4'($urandom_range(0, 15));
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (sb.size() != 0 || (pushed - p0) != (popped - q0) || (pushed - p0) == 0) begin
            errors++;
            $display("FAIL random_count: accepted=%0d emitted=%0d left=%0d, required equal and nonzero",
                     pushed - p0, popped - q0, sb.size());
        end
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_index  = 4'd2;
        tick();
        bus.in_index  = 4'd6;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mr_full: ready=%b, required 0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_onehot !== 16'h0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mr_state: valid=%b word=%h ready=%b, required 0/0000/1",
                     bus.out_valid, bus.out_onehot, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mr_ghost: valid=%b word=%h, required no output",
                         bus.out_valid, bus.out_onehot);
            end
        end
    endtask

    task automatic test_range();
        bus12.out_ready = 1'b1;
        bus12.in_valid  = 1'b1;
        bus12.in_index  = 4'd13;
        tick();
        checks++;
        if (bus12.out_valid !== 1'b1 || bus12.out_onehot !== 12'h000) begin
            errors++;
            $display("FAIL range_oor: valid=%b word=%h, required 1/000", bus12.out_valid, bus12.out_onehot);
        end
`ifdef OURDECODER_RANGE_ERR_EN
        checks++;
        if (bus12.out_err !== 1'b1) begin
            errors++;
            $display("FAIL range_err_set: err=%b, required 1", bus12.out_err);
        end
`endif
        bus12.in_index = 4'd11;
        tick();
        checks++;
        if (bus12.out_valid !== 1'b1 || bus12.out_onehot !== 12'h800) begin
            errors++;
            $display("FAIL range_top: valid=%b word=%h, required 1/800", bus12.out_valid, bus12.out_onehot);
        end
`ifdef OURDECODER_RANGE_ERR_EN
        checks++;
        if (bus12.out_err !== 1'b0) begin
            errors++;
            $display("FAIL range_err_clr: err=%b, required 0", bus12.out_err);
        end
`endif
        bus12.in_valid = 1'b0;
        tick();
        checks++;
        if (bus12.out_valid !== 1'b0 || bus12.out_onehot !== 12'h000) begin
            errors++;
            $display("FAIL range_idle: valid=%b word=%h, required 0/000", bus12.out_valid, bus12.out_onehot);
        end
`ifdef OURDECODER_RANGE_ERR_EN
        checks++;
        if (bus12.out_err !== 1'b0) begin
            errors++;
            $display("FAIL range_err_idle: err=%b, required 0", bus12.out_err);
        end
`endif
    endtask

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_index    = '0;
        bus.out_ready   = 1'b0;
        bus12.in_valid  = 1'b0;
        bus12.in_index  = '0;
        bus12.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_random();
        test_mid_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        test_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
